top_in: RTL and testbench
=========================

// Module: top_in
// PURPOSE
// - Serialises one 64-bit word as 8 UART bytes on a single TX line.
// - Transfer is launched by a manual start pulse (push-button or host strobe).
// - Top-level "input side" block of the link: byte sequencer plus one UART transmitter.
// PARAMETERS
// - CLK_F     50_000_000        system clock frequency in Hz
// - UART_BPS  115200            baud rate
// - CLK_GOAL  CLK_F/UART_BPS    clocks per bit; integer-truncated, 434 at defaults
// PORTS
// - clk           in   1   system clock; all logic on its rising edge
// - rst_n         in   1   asynchronous, active-HIGH reset (name kept per codebase)
// - data_64       in   64  word to send; sampled only at transfer start
// - manual_start  in   1   start request; synchronous, level held >=1 clk
// - uart_txd      out  1   UART TX line; idle high
// BEHAVIOUR
// - Reset (rst_n=1, async): uart_txd=1, FSM=IDLE, counters=0, edge register=0.
// - Start detect: start_d <= manual_start each clk.
//   - start_pulse = manual_start & ~start_d.
//   - Held-high start = one request only.
// - IDLE + start_pulse at edge N:
//   - data_64 latched into shadow register.
//   - byte index = 0.
//   - uart_txd=0 from edge N (start bit).
// - Byte order: MSB byte first.
//   - byte0 = data[63:56] ... byte7 = data[7:0].
// - Frame is 8N1, LSB first: start(0), d0..d7, stop(1).
// - Every bit lasts exactly CLK_GOAL clocks.
//   - Bit counter runs 0..CLK_GOAL-1 and advances the bit at wrap.
// - Bytes sent back-to-back:
//   - next start bit follows immediately after the previous stop bit's CLK_GOAL clocks.
//   - No idle gap between bytes.
// - Busy time is 80*CLK_GOAL clocks (34720 clk = 694.4 us at defaults).
//   - After it, FSM returns to IDLE with uart_txd=1.
// - FSM states:
//   - IDLE -> START (on start_pulse).
//   - START -> DATA (after 1 bit time).
//   - DATA -> DATA (8 bit times).
//   - DATA -> STOP (after d7).
//   - STOP -> START (if byte index < 7; index+1).
//   - STOP -> IDLE (if index == 7).
// - While busy:
//   - start_pulse is ignored and not queued.
//   - data_64 changes do not affect the current transfer.
// - A start_pulse in the same clk that FSM enters IDLE is ignored.
//   - It is accepted from the next clk onward.
// - Reset mid-frame: line forced high immediately, transfer abandoned, no resume.
// - uart_txd is driven from a register (glitch-free); no combinational path from inputs.
// STRUCTURE
// - Shared package (uart_pkg): CLK_F/UART_BPS defaults, FSM state enum, FRAME_BITS=10, BYTES=8.
// - Sub-module uart_byte_tx:
//   - Inputs: clk, rst_n, tx_start, tx_data[7:0].
//   - Outputs: txd, tx_done.
//   - tx_done is a 1-clk pulse at end of the stop bit.
//   - top_in sequences 8 bytes through it.
// TESTING
// - Reset held, then released:
//   - uart_txd=1 throughout.
//   - No activity without manual_start.
// - Launch transfer:
//   - Stimulus: data_64=64'h2CFF0AEF8AE16865, manual_start high for 2 clk.
//   - Decoded bytes: 2C,FF,0A,EF,8A,E1,68,65.
//   - Each bit is 434 clk; line idle after 34720 clk.
// - Data change mid-transfer:
//   - Change data_64 to 64'hE429F657A7C2DB78 at ~86.8 us.
//   - Transmitted bytes are still those of 64'h2CFF0AEF8AE16865.
// - Start pulse during busy:
//   - Extra manual_start pulses mid-transfer are ignored.
//   - Exactly 8 frames; then a new pulse sends the new word.
// - Async reset mid-frame:
//   - Assert rst_n (high) during byte 3 data bits.
//   - uart_txd=1 before the next clk edge.
//   - No further frames after release.
// - Held start:
//   - manual_start held high for 100000 clk.
//   - Exactly one 8-byte transfer.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, frame constants, transmitter state type and byte selector
package uart_pkg;
   localparam int CLK_F_DEF    = 50_000_000;
   localparam int UART_BPS_DEF = 115200;
   localparam int FRAME_BITS   = 10;
   localparam int BYTES        = 8;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   function automatic logic [7:0] byte_of(input logic [63:0] w, input logic [2:0] k);
      return w[8*(7-int'(k)) +: 8];
   endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 LSB-first byte transmitter that chains frames with no idle gap
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int CLK_GOAL = CLK_F_DEF / UART_BPS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       txd,
   output logic       tx_done
);
   localparam int CW = CLK_GOAL > 1 ? $clog2(CLK_GOAL) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_GOAL - 1);
   tx_state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] sh;
   logic wrap, load, txd_n;
   assign wrap = cnt == LAST;
   // state, bit timer, shift register and the registered line driver
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
         txd     <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
         bit_idx <= (state == DATA && wrap) ? bit_idx + 1'b1 : bit_idx;
         sh      <= load ? tx_data : (state == DATA && wrap) ? sh >> 1 : sh;
         txd     <= txd_n;
      end
   // next state: a start request at the end of a stop bit chains straight into the next start bit
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = tx_start ? START : IDLE;
         START:   state_n = wrap ? DATA : START;
         DATA:    state_n = (wrap && bit_idx == 3'd7) ? STOP : DATA;
         STOP:    state_n = wrap ? (tx_start ? START : IDLE) : STOP;
         default: state_n = IDLE;
      endcase
   end
   // outputs: line level for the coming clock, byte load strobe, end-of-frame pulse
   always_comb begin
      load    = tx_start && (state == IDLE || (state == STOP && wrap));
      tx_done = state == STOP && wrap;
      txd_n   = state_n == START ? 1'b0 :
                state_n == DATA  ? ((state == DATA && wrap) ? sh[1] : sh[0]) : 1'b1;
   end
endmodule

// File: rtl/top_in.sv
// top_in: sends a 64-bit word as 8 back-to-back UART bytes, MSB byte first, on a start edge
module top_in
   import uart_pkg::*;
#(
   parameter int CLK_F    = CLK_F_DEF,
   parameter int UART_BPS = UART_BPS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] data_64,
   input  logic        manual_start,
   output logic        uart_txd
);
   localparam int CLK_GOAL = CLK_F / UART_BPS;
   logic start_d, busy, launch, last, tx_start, tx_done;
   logic [2:0] idx;
   logic [63:0] shadow;
   logic [7:0] tx_data;
   assign launch   = manual_start & ~start_d & ~busy;
   assign last     = idx == 3'(BYTES - 1);
   assign tx_start = launch | (tx_done & ~last);
   assign tx_data  = busy ? byte_of(shadow, idx + 3'd1) : data_64[63:56];
   // edge detect, word capture and byte sequencing; busy drops in the clock the last stop bit ends
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) begin
         start_d <= 1'b0;
         busy    <= 1'b0;
         idx     <= '0;
         shadow  <= '0;
      end else begin
         start_d <= manual_start;
         if (launch) begin
            shadow <= data_64;
            idx    <= '0;
            busy   <= 1'b1;
         end else if (tx_done) begin
            busy <= ~last;
            idx  <= idx + 1'b1;
         end
      end
   uart_byte_tx #(.CLK_GOAL(CLK_GOAL)) u_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .txd      (uart_txd),
      .tx_done  (tx_done)
   );
endmodule

// File: tb/tb_top_in.sv
// tb_top_in: scoreboard bench decoding UART frames from top_in and checking bytes and frame timing
module tb_top_in;
   localparam int CLK_F    = 50_000_000;
   localparam int UART_BPS = 3_125_000;
   localparam int G        = CLK_F / UART_BPS;
   localparam int FRAME    = 10 * G;
   localparam int XFER     = 8 * FRAME;
   localparam logic [63:0] WA = 64'h2CFF0AEF8AE16865;
   localparam logic [63:0] WB = 64'hE429F657A7C2DB78;
   typedef struct {
      logic [7:0] b;
      int t;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, manual_start = 1'b0, uart_txd;
   logic [63:0] data_64 = '0;
   int cyc = 0, vec = 0, errs = 0, frames = 0, last_l = 0;
   bit ignore = 1'b0;
   exp_t exp_q[$];

   top_in #(.CLK_F(CLK_F), .UART_BPS(UART_BPS)) dut (
      .clk          (clk),
      .rst_n        (rst),
      .data_64      (data_64),
      .manual_start (manual_start),
      .uart_txd     (uart_txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      logic [7:0] b;
      logic s0, sp;
      int t0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && uart_txd === 1'b0) begin
            t0 = cyc;
            repeat (G / 2) @(negedge clk);
            s0 = uart_txd;
            for (int i = 0; i < 8; i++) begin
               repeat (G) @(negedge clk);
               b[i] = uart_txd;
            end
            repeat (G) @(negedge clk);
            sp = uart_txd;
            frames++;
            if (!ignore) begin
               vec++;
               if (exp_q.size() == 0) begin
                  errs++;
                  $display("FAIL frame_extra: got byte %h at cyc %0d, required no frame", b, t0);
               end else begin
                  e = exp_q.pop_front();
                  vec += 2;
                  if ({s0, b, sp} !== {1'b0, e.b, 1'b1}) begin
                     errs++;
                     $display("FAIL frame_data: got start=%b byte=%h stop=%b, required 0 %h 1", s0, b, sp, e.b);
                  end
                  if (t0 != e.t) begin
                     errs++;
                     $display("FAIL frame_time: start bit seen at cyc %0d, required %0d", t0, e.t);
                  end
               end
            end
         end
      end
   end

   task automatic launch(input logic [63:0] d, input int hold, input bit push);
      @(negedge clk);
      data_64 = d;
      manual_start = 1'b1;
      last_l = cyc + 1;
      if (push)
         for (int k = 0; k < 8; k++)
            exp_q.push_back('{b: d[63-8*k -: 8], t: last_l + k * FRAME});
      repeat (hold) @(negedge clk);
      manual_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2 * XFER) begin
         @(negedge clk);
         n++;
      end
      vec++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL %s_timeout: %0d frames outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic count_lows(input int n, output int lows);
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (uart_txd !== 1'b1) lows++;
      end
   endtask

   task automatic test_reset;
      int lows;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      vec++;
      if (uart_txd !== 1'b1) begin
         errs++;
         $display("FAIL reset_line: uart_txd=%b, required 1", uart_txd);
      end
      rst = 1'b0;
      count_lows(20 * G, lows);
      vec++;
      if (lows != 0 || frames != 0) begin
         errs++;
         $display("FAIL reset_quiet: %0d low clocks %0d frames, required 0 0", lows, frames);
      end
   endtask

   task automatic test_launch;
      int f0 = frames, lows;
      launch(WA, 2, 1);
      wait_done("launch");
      while (cyc < last_l + XFER) @(negedge clk);
      count_lows(3 * G, lows);
      vec++;
      if (lows != 0 || frames - f0 != 8) begin
         errs++;
         $display("FAIL launch_end: %0d low clocks %0d frames, required 0 8", lows, frames - f0);
      end
   endtask

   task automatic test_data_change;
      int f0 = frames;
      launch(WA, 2, 1);
      repeat (FRAME) @(negedge clk);
      data_64 = WB;
      wait_done("data_change");
      repeat (2 * G) @(negedge clk);
      vec++;
      if (frames - f0 != 8) begin
         errs++;
         $display("FAIL data_change_frames: got %0d, required 8", frames - f0);
      end
   endtask

   task automatic test_busy_pulses;
      int f0 = frames, lows;
      launch(WA, 1, 1);
      repeat (3 * G) @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         manual_start = 1'b1;
         repeat (p + 1) @(negedge clk);
         manual_start = 1'b0;
         repeat (7 * G) @(negedge clk);
      end
      wait_done("busy");
      while (cyc < last_l + XFER - 1) @(negedge clk);
      manual_start = 1'b1;
      @(negedge clk);
      manual_start = 1'b0;
      count_lows(3 * G, lows);
      vec++;
      if (lows != 0 || frames - f0 != 8) begin
         errs++;
         $display("FAIL busy_ignored: %0d low clocks %0d frames, required 0 8", lows, frames - f0);
      end
      launch(WB, 1, 1);
      wait_done("busy_new");
      repeat (2 * G) @(negedge clk);
      vec++;
      if (frames - f0 != 16) begin
         errs++;
         $display("FAIL busy_new_frames: got %0d, required 16", frames - f0);
      end
   endtask

   task automatic test_idle_accept;
      launch(WB, 1, 1);
      while (cyc < last_l + XFER - 1) @(negedge clk);
      launch(WA, 1, 1);
      wait_done("idle_accept");
      repeat (2 * G) @(negedge clk);
   endtask

   task automatic test_held;
      int f0 = frames, lows;
      launch(WB, 5000, 1);
      wait_done("held");
      count_lows(3 * G, lows);
      vec++;
      if (lows != 0 || frames - f0 != 8) begin
         errs++;
         $display("FAIL held_once: %0d low clocks %0d frames, required 0 8", lows, frames - f0);
      end
   endtask

   task automatic test_reset_mid;
      int f0, lows;
      ignore = 1'b1;
      launch(WA, 1, 0);
      while (cyc < last_l + 35 * G + G / 2) @(negedge clk);
      vec++;
      if (uart_txd !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid_pre: uart_txd=%b, required 0", uart_txd);
      end
      rst = 1'b1;
      #1;
      vec++;
      if (uart_txd !== 1'b1) begin
         errs++;
         $display("FAIL reset_mid_async: uart_txd=%b, required 1", uart_txd);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (12 * G) @(negedge clk);
      ignore = 1'b0;
      f0 = frames;
      count_lows(2 * XFER, lows);
      vec++;
      if (lows != 0 || frames != f0) begin
         errs++;
         $display("FAIL reset_mid_quiet: %0d low clocks %0d frames, required 0 0", lows, frames - f0);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at cyc %0d, required finish", cyc);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_launch();
      test_data_change();
      test_busy_pulses();
      test_idle_accept();
      test_held();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
